bram_frame_reader: RTL and testbench

- Read-side port driver for the 8-bit × 8192 pixel BRAM used by the edge-detection pipeline.
- On a start command, it issues sequential reads from a base address for a programmed pixel count.
- It absorbs the BRAM read latency with a small credit-controlled FIFO.
- It presents pixels as a valid/ready stream with last-beat marking to the downstream filter stage.

---
 rtl/bram_frame_reader.sv | 188 ++++++++++++++++++
 tb/tb_bram_frame_reader.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_frame_reader.sv
// Read-side driver for the pixel BRAM: issues sequential reads for a programmed
// pixel count and re-times the returned data into a valid/ready stream.
module bram_frame_reader #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 2;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] count_ones(input logic [RD_LAT-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  state_t              state_r, state_next_s;
  logic [ADDR_W-1:0]   base_r;
  logic [ADDR_W:0]     len_r;
  logic [ADDR_W:0]     issued_r;
  logic [ADDR_W:0]     pushed_r;
  logic [ADDR_W-1:0]   last_addr_r;
  logic [RD_LAT-1:0]   vld_pipe_r;
  logic [RD_LAT:0]     vld_ext_s;
  logic [DATA_W-1:0]   fifo_data_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_r;
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]    fifo_count_r;
  logic [CNT_W-1:0]    inflight_s;
  logic [ADDR_W-1:0]   cur_addr_s;
  logic                issue_s, push_s, pop_s, accept_s;

  // Credit check: FIFO entries plus reads in flight must leave room for one more.
  assign inflight_s = count_ones(vld_pipe_r);
  assign cur_addr_s = base_r + issued_r[ADDR_W-1:0];
  assign issue_s    = (state_r == ST_READ) && (issued_r < len_r)
                      && ((fifo_count_r + inflight_s) < DEPTH_C);
  assign push_s     = vld_pipe_r[RD_LAT-1];
  assign pop_s      = m_valid & m_ready;
  assign accept_s   = (state_r == ST_IDLE) && start;
  assign vld_ext_s  = {vld_pipe_r, issue_s};

  assign ena     = issue_s;
  assign wea     = 1'b0;
  assign addra   = issue_s ? cur_addr_s : last_addr_r;
  assign busy    = (state_r != ST_IDLE);
  assign done    = (state_r == ST_FIN);
  assign m_valid = (fifo_count_r != '0);
  assign m_data  = fifo_data_r[rd_ptr_r];
  assign m_last  = fifo_last_r[rd_ptr_r] & m_valid;

  // Next-state logic; DRAIN leaves on the handshake of the tagged last beat.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_next_s = ST_FIN;
          end else begin
            state_next_s = ST_READ;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (issued_r == len_r) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (pop_s && m_last) begin
          state_next_s = ST_FIN;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_FIN:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, command registers and issue counter.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      base_r      <= '0;
      len_r       <= '0;
      issued_r    <= '0;
      last_addr_r <= '0;
      vld_pipe_r  <= '0;
    end else begin
      state_r    <= state_next_s;
      vld_pipe_r <= vld_ext_s[RD_LAT-1:0];
      if (accept_s) begin
        base_r   <= base_addr;
        len_r    <= length;
        issued_r <= '0;
      end else if (issue_s) begin
        issued_r <= issued_r + (ADDR_W+1)'(1);
      end else begin
        issued_r <= issued_r;
      end
      if (issue_s) begin
        last_addr_r <= cur_addr_s;
      end else begin
        last_addr_r <= last_addr_r;
      end
    end
  end

  // Output FIFO; last flag is tagged from the push index so it survives stalls.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_r[i] <= '0;
      end
      fifo_last_r  <= '0;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      fifo_count_r <= '0;
      pushed_r     <= '0;
    end else begin
      if (accept_s) begin
        pushed_r <= '0;
      end else if (push_s) begin
        pushed_r <= pushed_r + (ADDR_W+1)'(1);
      end else begin
        pushed_r <= pushed_r;
      end
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= douta;
        fifo_last_r[wr_ptr_r] <= (pushed_r == (len_r - (ADDR_W+1)'(1)));
        wr_ptr_r              <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + CNT_W'(1);
        2'b01:   fifo_count_r <= fifo_count_r - CNT_W'(1);
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_frame_reader.sv
// Directed bench for bram_frame_reader: one instance at RD_LAT=1, one at RD_LAT=2,
// each driving a behavioural BRAM whose contents are a fixed function of address.
module tb_bram_frame_reader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start0, busy0, done0, ena0, wea0, mvalid0, mready0, mlast0;
  logic [12:0] base0, addra0;
  logic [13:0] len0;
  logic [7:0]  douta0, mdata0;
  logic        start1, busy1, done1, ena1, wea1, mvalid1, mready1, mlast1;
  logic [12:0] base1, addra1;
  logic [13:0] len1;
  logic [7:0]  douta1, mdata1, stage1;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [7:0] pix(input logic [12:0] a);
    logic [12:0] t;
    t = (a * 13'd37) ^ (a >> 4);
    return t[7:0] ^ 8'h5A;
  endfunction

  bram_frame_reader #(.ADDR_W(13), .DATA_W(8), .RD_LAT(1), .FIFO_DEPTH(4)) u0 (
    .clka(clk), .rst_n(rst_n), .start(start0), .base_addr(base0), .length(len0),
    .busy(busy0), .done(done0), .ena(ena0), .wea(wea0), .addra(addra0),
    .douta(douta0), .m_data(mdata0), .m_valid(mvalid0), .m_ready(mready0),
    .m_last(mlast0));

  bram_frame_reader #(.ADDR_W(13), .DATA_W(8), .RD_LAT(2), .FIFO_DEPTH(4)) u1 (
    .clka(clk), .rst_n(rst_n), .start(start1), .base_addr(base1), .length(len1),
    .busy(busy1), .done(done1), .ena(ena1), .wea(wea1), .addra(addra1),
    .douta(douta1), .m_data(mdata1), .m_valid(mvalid1), .m_ready(mready1),
    .m_last(mlast1));

  always @(posedge clk) begin
    if (ena0) douta0 <= pix(addra0);
    if (ena1) stage1 <= pix(addra1);
    douta1 <= stage1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    smp();
    n_cmp++;
    if ({busy0, done0, ena0, wea0, mvalid0, mlast0} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctl0 got %b want 000000", {busy0, done0, ena0, wea0, mvalid0, mlast0});
    end
    n_cmp++;
    if ({addra0, mdata0} !== 21'd0) begin
      n_bad++;
      $display("FAIL reset_bus0 got addra=%0d data=%0d want 0/0", addra0, mdata0);
    end
    n_cmp++;
    if ({busy1, done1, ena1, wea1, mvalid1, mlast1, addra1, mdata1} !== 27'd0) begin
      n_bad++;
      $display("FAIL reset_all1 got %h want 0", {busy1, done1, ena1, wea1, mvalid1, mlast1, addra1, mdata1});
    end
    rst_n = 1'b1;
    tick();
  endtask

  // base 0, length 16, plus an ignored start (base 500, length 3) at cycle 5
  task automatic test_basic();
    logic [4:0] exp_ctl;
    for (int c = 0; c < 24; c++) begin
      start0 = (c == 0) || (c == 5);
      base0  = (c == 5) ? 13'd500 : 13'd0;
      len0   = (c == 5) ? 14'd3 : 14'd16;
      smp();
      exp_ctl = {(c >= 1 && c <= 16), (c >= 1 && c <= 19), (c == 19), (c >= 3 && c <= 18), (c == 18)};
      n_cmp++;
      if ({ena0, busy0, done0, mvalid0, mlast0} !== exp_ctl) begin
        n_bad++;
        $display("FAIL basic_ctl c=%0d got %b want %b", c, {ena0, busy0, done0, mvalid0, mlast0}, exp_ctl);
      end
      if (c >= 1 && c <= 16) begin
        n_cmp++;
        if (addra0 !== 13'(c - 1)) begin
          n_bad++;
          $display("FAIL basic_addr c=%0d got %0d want %0d", c, addra0, c - 1);
        end
      end
      if (c >= 3 && c <= 18) begin
        n_cmp++;
        if (mdata0 !== pix(13'(c - 3))) begin
          n_bad++;
          $display("FAIL basic_data c=%0d got %h want %h", c, mdata0, pix(13'(c - 3)));
        end
      end
      tick();
    end
    start0 = 1'b0;
  endtask

  task automatic test_wrap();
    logic [12:0] got_a [8];
    logic [12:0] exp_a [4];
    logic [7:0]  got_d [8];
    logic        got_l [8];
    int na, nb, nd;
    exp_a[0] = 13'd8190; exp_a[1] = 13'd8191; exp_a[2] = 13'd0; exp_a[3] = 13'd1;
    na = 0; nb = 0; nd = 0;
    mready0 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      start0 = (c == 0);
      base0  = 13'd8190;
      len0   = 14'd4;
      smp();
      if (ena0 && na < 8) begin got_a[na] = addra0; na++; end
      if (mvalid0 && mready0 && nb < 8) begin got_d[nb] = mdata0; got_l[nb] = mlast0; nb++; end
      if (done0) nd++;
      tick();
    end
    start0 = 1'b0;
    n_cmp++;
    if (na != 4 || nb != 4 || nd != 1) begin
      n_bad++;
      $display("FAIL wrap_counts got reads=%0d beats=%0d dones=%0d want 4/4/1", na, nb, nd);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (got_a[k] !== exp_a[k] || got_d[k] !== pix(exp_a[k]) || got_l[k] !== (k == 3)) begin
          n_bad++;
          $display("FAIL wrap_beat k=%0d got a=%0d d=%h l=%b want a=%0d d=%h l=%b",
                   k, got_a[k], got_d[k], got_l[k], exp_a[k], pix(exp_a[k]), (k == 3));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int issued, popped, stalls, c;
    logic prev_stall, prev_last, seen_done;
    logic [7:0] prev_data;
    issued = 0; popped = 0; stalls = 0;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = 8'd0; seen_done = 1'b0;
    for (c = 0; c < 400; c++) begin
      start0  = (c == 0);
      base0   = 13'd100;
      len0    = 14'd32;
      mready0 = 1'($urandom_range(0, 1));
      smp();
      if (prev_stall) begin
        n_cmp++;
        if (mvalid0 !== 1'b1 || mdata0 !== prev_data || mlast0 !== prev_last) begin
          n_bad++;
          $display("FAIL bp_hold c=%0d got v=%b d=%h l=%b want 1/%h/%b", c, mvalid0, mdata0, mlast0, prev_data, prev_last);
        end
      end
      n_cmp++;
      if (u0.fifo_count_r > 4'd4) begin
        n_bad++;
        $display("FAIL bp_fifo_overflow c=%0d got %0d want <=4", c, u0.fifo_count_r);
      end
      if (busy0 && !ena0 && issued < 32) stalls++;
      if (ena0) begin
        n_cmp++;
        if (issued - popped >= 4 || addra0 !== 13'(100 + issued)) begin
          n_bad++;
          $display("FAIL bp_issue c=%0d got outstanding=%0d addr=%0d want <4/%0d", c, issued - popped, addra0, 100 + issued);
        end
        issued++;
      end
      if (mvalid0 && mready0) begin
        n_cmp++;
        if (mdata0 !== pix(13'(100 + popped)) || mlast0 !== (popped == 31)) begin
          n_bad++;
          $display("FAIL bp_beat k=%0d got d=%h l=%b want d=%h l=%b", popped, mdata0, mlast0, pix(13'(100 + popped)), (popped == 31));
        end
        popped++;
      end
      prev_stall = mvalid0 && !mready0;
      prev_data  = mdata0;
      prev_last  = mlast0;
      if (done0) begin
        seen_done = 1'b1;
        break;
      end
      tick();
    end
    tick();
    start0 = 1'b0;
    mready0 = 1'b1;
    n_cmp++;
    if (!seen_done || popped != 32 || issued != 32 || stalls == 0) begin
      n_bad++;
      $display("FAIL bp_total got done=%b beats=%0d reads=%0d stalls=%0d want 1/32/32/>0", seen_done, popped, issued, stalls);
    end
  endtask

  // zero length; start in FIN ignored, start right after FIN accepted
  task automatic test_zero();
    logic [3:0] exp_ctl;
    mready0 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      start0 = (c <= 2);
      base0  = 13'd7;
      len0   = (c == 1) ? 14'd5 : 14'd0;
      smp();
      exp_ctl = {(c == 1 || c == 3), (c == 1 || c == 3), 1'b0, 1'b0};
      n_cmp++;
      if ({busy0, done0, ena0, mvalid0} !== exp_ctl) begin
        n_bad++;
        $display("FAIL zero_ctl c=%0d got %b want %b", c, {busy0, done0, ena0, mvalid0}, exp_ctl);
      end
      tick();
    end
    start0 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int nb, nd;
    mready0 = 1'b1;
    nb = 0;
    for (int c = 0; c < 20; c++) begin
      start0 = (c == 0);
      base0  = 13'd200;
      len0   = 14'd20;
      rst_n  = (c != 8);
      smp();
      if (c < 8 && mvalid0) begin
        n_cmp++;
        if (mdata0 !== pix(13'(200 + nb))) begin
          n_bad++;
          $display("FAIL rmid_pre k=%0d got %h want %h", nb, mdata0, pix(13'(200 + nb)));
        end
        nb++;
      end
      if (c == 9) begin
        n_cmp++;
        if ({busy0, done0, ena0, wea0, mvalid0, mlast0, addra0, mdata0} !== 27'd0) begin
          n_bad++;
          $display("FAIL rmid_reset got %h want 0", {busy0, done0, ena0, wea0, mvalid0, mlast0, addra0, mdata0});
        end
      end
      if (c > 9) begin
        n_cmp++;
        if ({busy0, done0, ena0, mvalid0} !== 4'b0) begin
          n_bad++;
          $display("FAIL rmid_quiet c=%0d got %b want 0000", c, {busy0, done0, ena0, mvalid0});
        end
      end
      tick();
    end
    rst_n = 1'b1;
    nb = 0; nd = 0;
    for (int c = 0; c < 20; c++) begin
      start0 = (c == 0);
      base0  = 13'd40;
      len0   = 14'd3;
      smp();
      if (mvalid0 && mready0) begin
        n_cmp++;
        if (mdata0 !== pix(13'(40 + nb)) || mlast0 !== (nb == 2)) begin
          n_bad++;
          $display("FAIL rmid_post k=%0d got d=%h l=%b want d=%h l=%b", nb, mdata0, mlast0, pix(13'(40 + nb)), (nb == 2));
        end
        nb++;
      end
      if (done0) nd++;
      tick();
    end
    start0 = 1'b0;
    n_cmp++;
    if (nb != 3 || nd != 1) begin
      n_bad++;
      $display("FAIL rmid_count got beats=%0d dones=%0d want 3/1", nb, nd);
    end
  endtask

  task automatic test_lat2();
    logic [4:0] exp_ctl;
    mready1 = 1'b1;
    for (int c = 0; c < 74; c++) begin
      start1 = (c == 0);
      base1  = 13'd1000;
      len1   = 14'd64;
      smp();
      exp_ctl = {(c >= 1 && c <= 64), (c >= 1 && c <= 68), (c == 68), (c >= 4 && c <= 67), (c == 67)};
      n_cmp++;
      if ({ena1, busy1, done1, mvalid1, mlast1} !== exp_ctl || wea1 !== 1'b0) begin
        n_bad++;
        $display("FAIL lat2_ctl c=%0d got %b wea=%b want %b wea=0", c, {ena1, busy1, done1, mvalid1, mlast1}, wea1, exp_ctl);
      end
      if (c >= 1 && c <= 64) begin
        n_cmp++;
        if (addra1 !== 13'(1000 + c - 1)) begin
          n_bad++;
          $display("FAIL lat2_addr c=%0d got %0d want %0d", c, addra1, 1000 + c - 1);
        end
      end
      if (c >= 4 && c <= 67) begin
        n_cmp++;
        if (mdata1 !== pix(13'(1000 + c - 4))) begin
          n_bad++;
          $display("FAIL lat2_data c=%0d got %h want %h", c, mdata1, pix(13'(1000 + c - 4)));
        end
      end
      tick();
    end
    start1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; base0 = 13'd0; len0 = 14'd0; mready0 = 1'b1;
    start1 = 1'b0; base1 = 13'd0; len1 = 14'd0; mready1 = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero();
    test_reset_mid();
    test_lat2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
